// File: rtl/multicyc_exec_unit_pkg.sv
// Shared CPU types for the multi-cycle multiply/divide unit and its issuer.
package multicyc_exec_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } oper_t;

  typedef struct packed {
    logic        is_multicyc;
    oper_t       op;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [63:0] hilo;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [63:0] hilo;
  } multicyc_resp_t;

  localparam int unsigned DIV_STEPS = 32;

  function automatic logic is_mul_op(oper_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(oper_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/multicyc_divider.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per cycle.
module multicyc_divider
  import multicyc_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dsr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
        quo  <= dividend;
        rem  <= '0;
        dsr  <= divisor;
      end else if (busy) begin
        // Restore (keep the shifted partial remainder) when the trial subtract goes negative
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= shifted[31:0];
          quo <= {quo[30:0], 1'b0};
        end
        cnt <= cnt + 5'd1;
        if (cnt == 5'(DIV_STEPS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/multicyc_exec_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU execution unit returning a {hi,lo} result.
module multicyc_exec_unit
  import multicyc_exec_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  multicyc_req_t  multicyc_req,
  output multicyc_resp_t multicyc_resp
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic        ready;
  logic        accept;
  logic        accept_mul;
  logic        accept_div;
  oper_t       op_p0;
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic        mul_stage_p1;
  logic [63:0] prod_p1;
  logic [63:0] hilo_p2;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        unused_hilo;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] mul_product(input oper_t op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic               sgn;
    sgn   = (op == OP_MULT);
    a_ext = {{32{sgn & a[31]}}, a};
    b_ext = {{32{sgn & b[31]}}, b};
    return a_ext * b_ext;
  endfunction

  function automatic logic [63:0] div_fixup(input oper_t op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] q,
                                            input logic [31:0] r);
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic        sgn;
    sgn = (op == OP_DIV);
    q_s = (sgn && (a[31] ^ b[31])) ? (~q + 32'd1) : q;
    r_s = (sgn && a[31]) ? (~r + 32'd1) : r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {r_s, q_s};
  endfunction

  assign ready      = (state == IDLE) || (state == DONE);
  assign accept     = ready && multicyc_req.is_multicyc;
  assign accept_mul = accept && is_mul_op(multicyc_req.op);
  assign accept_div = accept && is_div_op(multicyc_req.op);
  assign unused_hilo = ^multicyc_req.hilo;

  multicyc_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_div),
    .dividend  (abs32(multicyc_req.reg0, multicyc_req.op == OP_DIV)),
    .divisor   (abs32(multicyc_req.reg1, multicyc_req.op == OP_DIV)),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept_mul)      state_nxt = MUL;
        else if (accept_div) state_nxt = DIV;
        else                 state_nxt = IDLE;
      end
      MUL:     if (mul_stage_p1) state_nxt = DONE;
      DIV:     if (div_done)     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operands captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0 <= OP_NOP;
      a_p0  <= '0;
      b_p0  <= '0;
    end else if (accept_mul || accept_div) begin
      op_p0 <= multicyc_req.op;
      a_p0  <= multicyc_req.reg0;
      b_p0  <= multicyc_req.reg1;
    end
  end

  // Stage p1: product registered so the multiplier never feeds hilo directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_stage_p1 <= 1'b0;
      prod_p1      <= '0;
    end else if (accept_mul) begin
      mul_stage_p1 <= 1'b0;
    end else if (state == MUL && !mul_stage_p1) begin
      mul_stage_p1 <= 1'b1;
      prod_p1      <= mul_product(op_p0, a_p0, b_p0);
    end
  end

  // Stage p2: result register, loaded only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_p2 <= '0;
    end else if (state == MUL && mul_stage_p1) begin
      hilo_p2 <= prod_p1;
    end else if (state == DIV && div_done) begin
      hilo_p2 <= div_fixup(op_p0, a_p0, b_p0, div_quo, div_rem);
    end
  end

  always_comb begin
    multicyc_resp       = '0;
    multicyc_resp.ready = ready;
    multicyc_resp.valid = (state == DONE);
    multicyc_resp.hilo  = hilo_p2;
  end

endmodule

// File: tb/tb_multicyc_exec_unit.sv
// Directed self-checking bench for multicyc_exec_unit.
module tb_multicyc_exec_unit;
  import multicyc_exec_unit_pkg::*;

  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 34;
  localparam int NSTREAM = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  multicyc_req_t  req;
  multicyc_resp_t resp;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  oper_t       s_op  [NSTREAM];
  logic [31:0] s_a   [NSTREAM];
  logic [31:0] s_b   [NSTREAM];
  logic [63:0] s_exp [NSTREAM];

  multicyc_exec_unit dut (
    .clk           (clk),
    .rst           (rst),
    .multicyc_req  (req),
    .multicyc_resp (resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp.valid === 1'b1) valid_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input oper_t op, input logic [31:0] a, input logic [31:0] b);
    req.is_multicyc = 1'b1;
    req.op          = op;
    req.reg0        = a;
    req.reg1        = b;
    req.hilo        = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp.valid !== 1'b1 && n < 60);
    check({tag, "_valid"}, 64'(resp.valid), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic run_op(input string tag, input oper_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    lat = (op == OP_DIV || op == OP_DIVU) ? LAT_DIV : LAT_MUL;
    @(negedge clk);
    check({tag, "_ready_in"}, 64'(resp.ready), 64'd1);
    drive(op, a, b);
    @(posedge clk);
    #1 req.is_multicyc = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 64'(resp.ready), 64'd0);
    wait_valid(tag, lat - 1);
    check({tag, "_hilo"}, resp.hilo, exp);
    check({tag, "_done_ready"}, 64'(resp.ready), 64'd1);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(resp.valid), 64'd0);
  endtask

  initial begin
    int vc0;
    req = '0;
    s_op[0] = OP_MULTU; s_a[0] = 32'h0001_0000; s_b[0] = 32'h0001_0000; s_exp[0] = 64'h00000001_00000000;
    s_op[1] = OP_DIV;   s_a[1] = 32'h0000_0064; s_b[1] = 32'hFFFF_FFF9; s_exp[1] = 64'h00000002_FFFFFFF2;
    s_op[2] = OP_MULT;  s_a[2] = 32'h8000_0000; s_b[2] = 32'h8000_0000; s_exp[2] = 64'h40000000_00000000;
    s_op[3] = OP_DIVU;  s_a[3] = 32'hFFFF_FFFF; s_b[3] = 32'h0000_0010; s_exp[3] = 64'h0000000F_0FFFFFFF;
    s_op[4] = OP_DIV;   s_a[4] = 32'hFFFF_FF9C; s_b[4] = 32'h0000_0007; s_exp[4] = 64'hFFFFFFFE_FFFFFFF2;
    s_op[5] = OP_DIV;   s_a[5] = 32'h0000_0005; s_b[5] = 32'h0000_0000; s_exp[5] = 64'h00000005_FFFFFFFF;
    s_op[6] = OP_MULT;  s_a[6] = 32'hFFFF_FFFF; s_b[6] = 32'hFFFF_FFFF; s_exp[6] = 64'h00000000_00000001;
    s_op[7] = OP_MULT;  s_a[7] = 32'h0000_0003; s_b[7] = 32'hFFFF_FFFB; s_exp[7] = 64'hFFFFFFFF_FFFFFFF1;

    #1;
    check("rst_ready", 64'(resp.ready), 64'd1);
    check("rst_valid", 64'(resp.valid), 64'd0);
    check("rst_hilo", resp.hilo, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("mult",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFE);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h00000001_FFFFFFFE);
    run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu",  OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 64'h00000001_7FFFFFFC);
    run_op("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
    run_op("divu_z", OP_DIVU, 32'h1234_5678, 32'h0000_0000, 64'h12345678_FFFFFFFF);

    // A non-multicyc op with the strobe set must leave the unit idle
    @(negedge clk);
    drive(OP_ADD, 32'h1, 32'h2);
    @(posedge clk);
    #1 req.is_multicyc = 1'b0;
    vc0 = valid_cnt;
    repeat (5) @(negedge clk);
    check("nop_ready", 64'(resp.ready), 64'd1);
    check("nop_valid_cnt", 64'(valid_cnt), 64'(vc0));
    check("nop_hilo", resp.hilo, 64'h12345678_FFFFFFFF);

    // Back-to-back stream, next request issued in each DONE cycle
    vc0 = valid_cnt;
    @(negedge clk);
    drive(s_op[0], s_a[0], s_b[0]);
    @(posedge clk);
    #1 req.is_multicyc = 1'b0;
    for (int i = 0; i < NSTREAM; i++) begin
      wait_valid($sformatf("s%0d", i), (s_op[i] == OP_DIV || s_op[i] == OP_DIVU) ? LAT_DIV : LAT_MUL);
      check($sformatf("s%0d_hilo", i), resp.hilo, s_exp[i]);
      if (i + 1 < NSTREAM) begin
        drive(s_op[i+1], s_a[i+1], s_b[i+1]);
        @(posedge clk);
        #1 req.is_multicyc = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    check("stream_valid_cnt", 64'(valid_cnt - vc0), 64'(NSTREAM));

    // Reset in the middle of a divide aborts it
    @(negedge clk);
    drive(OP_DIVU, 32'h0000_0064, 32'h0000_0003);
    @(posedge clk);
    #1 req.is_multicyc = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(resp.ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(resp.ready), 64'd1);
    check("mid_rst_valid", 64'(resp.valid), 64'd0);
    check("mid_rst_hilo", resp.hilo, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    vc0 = valid_cnt;
    repeat (40) @(negedge clk);
    check("mid_no_stale", 64'(valid_cnt), 64'(vc0));
    run_op("post_rst", OP_DIVU, 32'h0000_0064, 32'h0000_0003, 64'h00000001_00000021);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
